// File: rtl/vga_sync_recovery.sv
// Receive-side VGA timing recovery: rebuilds pixel position from incoming
// HSync/VSync edges, qualifies the timing over consecutive frames, and
// presents position/visible/strobe/video aligned one cycle behind the input.
module vga_sync_recovery #(
   parameter int VIDEO_WIDTH     = 3,
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT_PORCH   = 16,
   parameter int H_TOTAL         = 800,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT_PORCH   = 10,
   parameter int V_TOTAL         = 525,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_hsync,
   input  logic                   i_vsync,
   input  logic [VIDEO_WIDTH-1:0] i_red_video,
   input  logic [VIDEO_WIDTH-1:0] i_grn_video,
   input  logic [VIDEO_WIDTH-1:0] i_blu_video,
   output logic [9:0]             o_hpos,
   output logic [9:0]             o_vpos,
   output logic                   o_visible,
   output logic                   o_frame_strobe,
   output logic                   o_locked,
   output logic                   o_sync_error,
   output logic [VIDEO_WIDTH-1:0] o_red_video,
   output logic [VIDEO_WIDTH-1:0] o_grn_video,
   output logic [VIDEO_WIDTH-1:0] o_blu_video
);

   localparam int GW = $clog2(LOCK_FRAMES + 1);

   localparam logic [9:0]    H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0]    V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]    HS_POS     = 10'(H_VISIBLE + H_FRONT_PORCH);
   localparam logic [9:0]    VS_POS     = 10'(V_VISIBLE + V_FRONT_PORCH);
   localparam logic [GW-1:0] LOCK_COUNT = GW'(LOCK_FRAMES);
   localparam logic          SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          good_q, good_d;
   logic                   dirty_q, dirty_d;
   logic                   error_d;
   logic                   hsync_q, vsync_q;
   logic [9:0]             hpos_q, vpos_q;
   logic                   sync_error_q;
   logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;

   logic       h_edge, v_edge, h_wrap, checking;
   logic       h_mis, v_mis, mismatch;
   logic [9:0] e_h, e_v, n_h, n_v;
   logic [GW-1:0] good_inc;

   // Edge detection, free-running prediction and timing checks.
   always_comb begin
      h_edge   = (i_hsync != SYNC_IDLE) && (hsync_q == SYNC_IDLE);
      v_edge   = (i_vsync != SYNC_IDLE) && (vsync_q == SYNC_IDLE);
      h_wrap   = (hpos_q == H_LAST);
      e_h      = h_wrap ? '0 : hpos_q + 10'd1;
      e_v      = vpos_q;
      if (h_wrap) begin
         e_v = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
      end
      checking = (state_q != SEARCH);
      // A present edge must land on the predicted position; an absent edge
      // is only an error once the stream has been qualified at least once.
      h_mis    = h_edge ? (e_h != HS_POS) : (checking && (e_h == HS_POS));
      v_mis    = v_edge ? ((e_v != VS_POS) || (e_h != '0))
                        : (checking && (e_h == '0) && (e_v == VS_POS));
      mismatch = h_mis || v_mis;
      n_h      = h_edge ? HS_POS : (v_edge ? '0 : e_h);
      n_v      = v_edge ? VS_POS : e_v;
   end

   // Lock qualification state machine: next state, frame count and error.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d  = state_q;
      good_d   = good_q;
      dirty_d  = dirty_q;
      error_d  = 1'b0;
      good_inc = good_q + 1'b1;
      unique case (state_q)
         SEARCH: begin
            if (v_edge) begin
               state_d = ACQUIRE;
               good_d  = '0;
               dirty_d = 1'b0;
            end
         end
         ACQUIRE: begin
            if (v_edge) begin
               dirty_d = 1'b0;
               if (dirty_q || mismatch) begin
                  good_d = '0;
               end else begin
                  good_d = good_inc;
                  if (good_inc == LOCK_COUNT) state_d = LOCKED;
               end
            end else if (mismatch) begin
               dirty_d = 1'b1;
            end
         end
         LOCKED: begin
            if (mismatch) begin
               state_d = SEARCH;
               error_d = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   // State, counters and one-cycle-delayed video; reset is synchronous.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the pre-edge value of every other register.
      if (!i_rst_n) begin
         state_q      <= SEARCH;
         good_q       <= '0;
         dirty_q      <= 1'b0;
         hsync_q      <= SYNC_IDLE;
         vsync_q      <= SYNC_IDLE;
         hpos_q       <= '0;
         vpos_q       <= '0;
         sync_error_q <= 1'b0;
         red_q        <= '0;
         grn_q        <= '0;
         blu_q        <= '0;
      end else begin
         state_q      <= state_d;
         good_q       <= good_d;
         dirty_q      <= dirty_d;
         hsync_q      <= i_hsync;
         vsync_q      <= i_vsync;
         hpos_q       <= n_h;
         vpos_q       <= n_v;
         sync_error_q <= error_d;
         red_q        <= i_red_video;
         grn_q        <= i_grn_video;
         blu_q        <= i_blu_video;
      end
   end

   // Output decode from registered state: all zero straight after reset.
   always_comb begin
      o_hpos         = hpos_q;
      o_vpos         = vpos_q;
      o_locked       = (state_q == LOCKED);
      o_sync_error   = sync_error_q;
      o_visible      = o_locked && (hpos_q < H_VIS) && (vpos_q < V_VIS);
      o_frame_strobe = o_locked && (hpos_q == '0) && (vpos_q == '0);
      o_red_video    = o_visible ? red_q : '0;
      o_grn_video    = o_visible ? grn_q : '0;
      o_blu_video    = o_visible ? blu_q : '0;
   end

endmodule

// File: doc/vga_sync_recovery.md
Name: vga_sync_recovery

Overview:
Receive-side timing recovery for the VGA video path. Takes a raw video stream (RGB plus HSync/VSync, e.g. looped back or captured from another board), recovers pixel position, visible flag and frame strobe, and reports lock and sync errors. Its outputs match the position/visible/strobe/video set the pattern generator and video consumers already use, so a downstream pattern checker can run without access to the transmitter's counters.

Parameters:
VIDEO_WIDTH, 3, bits per colour channel
H_VISIBLE, 640, visible pixels per line
H_FRONT_PORCH, 16, pixels between visible end and HSync assertion
H_TOTAL, 800, pixels per line
V_VISIBLE, 480, visible lines per frame
V_FRONT_PORCH, 10, lines between visible end and VSync assertion
V_TOTAL, 525, lines per frame
SYNC_ACTIVE_LOW, 1, 1 = sync pulses are active-low
LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  synchronous active-low reset
i_hsync  in  1  incoming horizontal sync
i_vsync  in  1  incoming vertical sync
i_red_video / i_grn_video / i_blu_video  in  VIDEO_WIDTH each  incoming colour
o_hpos  out  10  recovered column
o_vpos  out  10  recovered line
o_visible  out  1  pixel in visible area and locked
o_frame_strobe  out  1  one-cycle pulse at (0,0) while locked
o_locked  out  1  timing locked
o_sync_error  out  1  one-cycle pulse on loss of lock
o_red_video / o_grn_video / o_blu_video  out  VIDEO_WIDTH each  colour aligned to o_hpos/o_vpos

Behaviour:
- Clock and reset fixed: single clock i_clk; reset i_rst_n synchronous, active-low.
- Reset (i_rst_n=0 at edge): all outputs 0, FSM=SEARCH, good-frame count 0, frame-dirty flag 0, previous-sync registers = inactive level. A sync already active on the first sample after reset counts as an assertion edge.
- Edge detect: assertion edge = sync sampled active now and inactive on previous sample (polarity per SYNC_ACTIVE_LOW).
- Latency: 1 cycle. Outputs reflect the input sample taken at the previous edge. Video outputs are registered inputs, forced to 0 when o_visible=0.
- Free-running counter (E = next value): hpos wraps H_TOTAL-1 -> 0. vpos increments on hpos wrap and wraps V_TOTAL-1 -> 0.
- HSync edge: hpos loads H_VISIBLE+H_FRONT_PORCH. Mismatch if E_hpos differs.
- VSync edge: vpos loads V_VISIBLE+V_FRONT_PORCH and hpos is treated as 0. Mismatch if E_vpos differs or E_hpos != 0. VSync edge with no HSync edge in the same cycle is legal.
- Missing-edge mismatch (ACQUIRE/LOCKED only):
  - E_hpos reaches H_VISIBLE+H_FRONT_PORCH without an HSync edge.
  - (E_hpos, E_vpos) reaches (0, V_VISIBLE+V_FRONT_PORCH) without a VSync edge.
  - Counter free-runs after a missing-edge mismatch.
- FSM:
  - SEARCH: counters follow edges, no checks. VSync edge -> ACQUIRE with good=0 and dirty=0.
  - ACQUIRE: any mismatch sets dirty. On VSync edge: if dirty or that edge mismatched, good=0; else good+1. Dirty clears. When good reaches LOCK_FRAMES -> LOCKED, and o_locked=1 on the following cycle.
  - LOCKED: any mismatch -> SEARCH and o_sync_error=1 for exactly one cycle. o_locked=0 on the same cycle as the error pulse.
- o_visible = LOCKED && hpos < H_VISIBLE && vpos < V_VISIBLE.
- o_frame_strobe = LOCKED && hpos==0 && vpos==0. One pulse per frame.
- Simultaneous HSync and VSync edges: both loads apply, both checks apply, and a mismatch from either counts once.
- Reset while LOCKED: outputs 0 next cycle, no o_sync_error pulse.

Test Plan:
1. Clean 640x480 stream from the in-codebase sync generator, starting at mid-frame -> first VSync edge enters ACQUIRE. o_locked rises 1 cycle after the 3rd VSync edge (LOCK_FRAMES=2). Afterwards o_hpos/o_vpos equal the generator's counters delayed 1 cycle, and o_frame_strobe pulses once per 420000 cycles.
2. Locked, pattern-4 colour bars fed in -> o_*_video equals input delayed 1 cycle for hpos<640/vpos<480, and is 0 at hpos 640..799 and at vpos 480..524.
3. Locked, one HSync edge on line 100 delayed 1 cycle -> single-cycle o_sync_error, o_locked=0 the same cycle. Relock after 3 further VSync edges.
4. Locked, one HSync pulse removed -> error pulse in the cycle E_hpos hits 656, o_visible=0 from then on.
5. ACQUIRE, one frame with V_TOTAL=526 injected -> good resets to 0. No o_sync_error. Lock needs 2 clean frames afterwards.
6. Reset asserted for 1 cycle while locked -> all outputs 0, no error pulse. Relock sequence repeats as in scenario 1.
